// File: rtl/dsp_seq_pkg.sv
// Shared constants for the DSP48A1 dot-product sequencer: opmode codes,
// sequencer states and the slice register configuration it assumes.
package dsp_seq_pkg;

   // OPMODE = {post-sub, pre-sub, carry, pre-add, Z[1:0], X[1:0]}
   localparam logic [7:0] OPMODE_FIRST = 8'h01;  // X=M, Z=0
   localparam logic [7:0] OPMODE_ACC   = 8'h09;  // X=M, Z=P
   localparam logic [7:0] OPMODE_HOLD  = 8'h08;  // X=0, Z=P

   localparam int A0REG     = 0;
   localparam int A1REG     = 1;
   localparam int B0REG     = 0;
   localparam int B1REG     = 1;
   localparam int MREG      = 1;
   localparam int PREG      = 1;
   localparam int OPMODEREG = 1;
   localparam bit B_INPUT_DIRECT       = 1'b1;
   localparam bit CARRYINSEL_OPMODE5   = 1'b1;

   localparam int MAX_TERMS_DEF = 1024;
   localparam int CNT_W_DEF     = 11;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DRAIN,
      OUT
   } state_e;

endpackage

// File: rtl/dsp_dot_seq_if.sv
// Operand stream and result handshake bundles for the dot-product sequencer.
interface dsp_stream_if;
   logic               s_valid;
   logic               s_ready;
   logic signed [17:0] s_a;
   logic signed [17:0] s_b;
   logic               s_last;

   modport master (output s_valid, s_a, s_b, s_last, input s_ready);
   modport slave  (input s_valid, s_a, s_b, s_last, output s_ready);
endinterface

interface dsp_res_if #(
   parameter int CNT_W = 11
);
   logic             res_valid;
   logic             res_ready;
   logic [47:0]      res_data;
   logic [CNT_W-1:0] res_terms;
   logic             res_trunc;

   modport master (output res_valid, res_data, res_terms, res_trunc, input res_ready);
   modport slave  (input res_valid, res_data, res_terms, res_trunc, output res_ready);
endinterface

// File: rtl/dsp_seq_dly.sv
// Fixed-depth register delay line with asynchronous reset.
module dsp_seq_dly #(
   parameter int           W       = 8,
   parameter int           N       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [N-1:0][W-1:0] pipe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe <= {N{RST_VAL}};
      end else begin
         pipe[0] <= d;
         for (int i = 1; i < N; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign q = pipe[N-1];

endmodule

// File: rtl/dsp_dot_seq.sv
// Feeds a DSP48A1 slice with operand pairs so it accumulates sum(a*b) over
// one s_last-delimited vector, then captures P onto the result port.
module dsp_dot_seq
   import dsp_seq_pkg::*;
#(
   parameter int DSP_LAT    = A1REG + MREG + PREG,
   parameter int OPMODE_DLY = MREG,
   parameter int MAX_TERMS  = MAX_TERMS_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic               CLK,
   input  logic               RST,
   dsp_stream_if.slave        s,
   dsp_res_if.master          res,
   output logic signed [17:0] dsp_a,
   output logic signed [17:0] dsp_b,
   output logic [47:0]        dsp_c,
   output logic [17:0]        dsp_d,
   output logic [7:0]         dsp_opmode,
   output logic               dsp_ce,
   output logic               dsp_rst,
   input  logic [47:0]        dsp_p
);

   localparam int DRAIN_LEN = DSP_LAT + OPMODE_DLY - 1;
   localparam int DCNT_W    = (DRAIN_LEN > 0) ? $clog2(DRAIN_LEN + 1) : 1;

   state_e           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
   logic [DCNT_W-1:0] dcnt, dcnt_n;
   logic             trunc, trunc_n;
   logic             s_rdy, acc, cap;
   logic [7:0]       tag;
   logic             rst_sync;
   logic [47:0]      res_data_q;
   logic [CNT_W-1:0] res_terms_q;
   logic             res_trunc_q;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      dcnt_n  = dcnt;
      trunc_n = trunc;
      cap     = 1'b0;
      s_rdy   = 1'b0;
      tag     = OPMODE_HOLD;
      cnt_inc = (state == IDLE) ? CNT_W'(1) : cnt + 1'b1;
      unique case (state)
         IDLE, ACCUM: begin
            s_rdy = !dsp_rst;
            if (s.s_valid && s_rdy) begin
               tag     = (state == IDLE) ? OPMODE_FIRST : OPMODE_ACC;
               cnt_n   = cnt_inc;
               trunc_n = 1'b0;
               state_n = ACCUM;
               if (s.s_last || cnt_inc == CNT_W'(MAX_TERMS)) begin
                  state_n = DRAIN;
                  dcnt_n  = DCNT_W'(DRAIN_LEN);
                  trunc_n = !s.s_last;
               end
            end
         end
         DRAIN: begin
            dcnt_n = dcnt - 1'b1;
            if (dcnt == '0) begin
               cap     = 1'b1;
               state_n = OUT;
            end
         end
         OUT: begin
            if (res.res_ready) state_n = IDLE;
         end
      endcase
   end

   assign acc = s.s_valid && s_rdy;

   // dsp_rst is held for two edges after RST so the synchronous slice reset
   // always sees a clock edge; CE comes up on the same edge it drops.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         cnt         <= '0;
         dcnt        <= '0;
         trunc       <= 1'b0;
         rst_sync    <= 1'b0;
         dsp_rst     <= 1'b1;
         dsp_ce      <= 1'b0;
         dsp_a       <= '0;
         dsp_b       <= '0;
         res_data_q  <= '0;
         res_terms_q <= '0;
         res_trunc_q <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         dcnt     <= dcnt_n;
         trunc    <= trunc_n;
         rst_sync <= 1'b1;
         dsp_rst  <= !rst_sync;
         dsp_ce   <= rst_sync;
         dsp_a    <= acc ? s.s_a : '0;
         dsp_b    <= acc ? s.s_b : '0;
         if (cap) begin
            res_data_q  <= dsp_p;
            res_terms_q <= cnt;
            res_trunc_q <= trunc;
         end
      end
   end

   // One extra stage aligns the tag with dsp_a/dsp_b; the remaining
   // OPMODE_DLY stages match the slice M register.
   dsp_seq_dly #(.W(8), .N(OPMODE_DLY + 1)) u_opm_dly (
      .clk (CLK),
      .rst (RST),
      .d   (tag),
      .q   (dsp_opmode)
   );

   assign dsp_c         = '0;
   assign dsp_d         = '0;
   assign s.s_ready     = s_rdy;
   assign res.res_valid = (state == OUT);
   assign res.res_data  = res_data_q;
   assign res.res_terms = res_terms_q;
   assign res.res_trunc = res_trunc_q;

endmodule

// File: tb/tb_dsp_dot_seq.sv
// Directed bench for dsp_dot_seq driving a behavioural DSP48A1 slice model;
// instance 0 uses MAX_TERMS=1024, instance 1 uses MAX_TERMS=4.
module tb_dsp_dot_seq;

   localparam int CNT_W = 11;
   localparam int LAT   = 4;  // last accept edge to res_valid edge

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   logic               s_valid [2];
   logic               s_ready [2];
   logic signed [17:0] s_a [2];
   logic signed [17:0] s_b [2];
   logic               s_last [2];
   logic               res_valid [2];
   logic               res_ready [2];
   logic [47:0]        res_data [2];
   logic [CNT_W-1:0]   res_terms [2];
   logic               res_trunc [2];
   logic signed [17:0] dsp_a [2];
   logic signed [17:0] dsp_b [2];
   logic [47:0]        dsp_c [2];
   logic [17:0]        dsp_d [2];
   logic [7:0]         dsp_opmode [2];
   logic               dsp_ce [2];
   logic               dsp_rst [2];

   for (genvar k = 0; k < 2; k++) begin : g_dut
      dsp_stream_if sif ();
      dsp_res_if #(.CNT_W(CNT_W)) rif ();
      logic signed [17:0] a1, b1;
      logic signed [47:0] m, p, xm, zp;
      logic [7:0]         opr;

      assign sif.s_valid   = s_valid[k];
      assign sif.s_a       = s_a[k];
      assign sif.s_b       = s_b[k];
      assign sif.s_last    = s_last[k];
      assign s_ready[k]    = sif.s_ready;
      assign rif.res_ready = res_ready[k];
      assign res_valid[k]  = rif.res_valid;
      assign res_data[k]   = rif.res_data;
      assign res_terms[k]  = rif.res_terms;
      assign res_trunc[k]  = rif.res_trunc;

      dsp_dot_seq #(.MAX_TERMS(k == 0 ? 1024 : 4), .CNT_W(CNT_W)) u_dut (
         .CLK        (clk),
         .RST        (rst),
         .s          (sif.slave),
         .res        (rif.master),
         .dsp_a      (dsp_a[k]),
         .dsp_b      (dsp_b[k]),
         .dsp_c      (dsp_c[k]),
         .dsp_d      (dsp_d[k]),
         .dsp_opmode (dsp_opmode[k]),
         .dsp_ce     (dsp_ce[k]),
         .dsp_rst    (dsp_rst[k]),
         .dsp_p      (p)
      );

      // Slice: A1/B1 -> M -> P with OPMODE register, sync reset, CE.
      assign xm = (opr[1:0] == 2'b01) ? m : 48'sd0;
      assign zp = (opr[3:2] == 2'b10) ? p : 48'sd0;
      always @(posedge clk) begin
         if (dsp_rst[k]) begin
            a1 <= '0; b1 <= '0; m <= '0; opr <= '0; p <= '0;
         end else if (dsp_ce[k]) begin
            a1  <= dsp_a[k];
            b1  <= dsp_b[k];
            m   <= 48'(a1) * 48'(b1);
            opr <= dsp_opmode[k];
            p   <= opr[7] ? zp - xm : zp + xm;
         end
      end
   end

   logic [7:0]         opm_log [1024];
   logic signed [17:0] a_log [1024];
   always @(negedge clk) begin
      opm_log[edge_cnt % 1024] = dsp_opmode[0];
      a_log[edge_cnt % 1024]   = dsp_a[0];
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out", name);
   endtask

   task automatic idle(int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send_beat(int u, logic signed [17:0] a, logic signed [17:0] b,
                            logic last, output int acc_e);
      acc_e = -1;
      s_valid[u] = 1'b1; s_a[u] = a; s_b[u] = b; s_last[u] = last;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (s_ready[u]) begin
            @(posedge clk); #1;
            acc_e = edge_cnt;
            break;
         end
         @(posedge clk); #1;
      end
      s_valid[u] = 1'b0; s_last[u] = 1'b0;
      if (acc_e < 0) timeout("send_beat");
   endtask

   task automatic wait_result(int u, logic [47:0] exp_data, int exp_terms,
                              logic exp_trunc, int last_e, string name);
      int seen = -1;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (res_valid[u]) begin seen = edge_cnt; break; end
      end
      if (seen < 0) timeout(name);
      else begin
         check({name, " data"}, res_data[u], exp_data);
         check({name, " terms"}, res_terms[u], exp_terms);
         check({name, " trunc"}, res_trunc[u], exp_trunc);
         if (last_e >= 0) check({name, " latency"}, seen - last_e, LAT);
      end
      @(posedge clk); #1;
   endtask

   typedef struct packed {
      int          a;
      int          b;
      int          gap;
      logic        last;
      logic [47:0] exp_data;
      int          exp_terms;
   } beat_t;

   beat_t tbl [12];
   int    acc_log [12];

   initial begin : main
      int e, e1, cnt_v;
      tbl = '{
         '{3, 4, 0, 1'b0, 48'd0, 0},
         '{5, 6, 0, 1'b0, 48'd0, 0},
         '{-2, 7, 0, 1'b1, 48'd28, 3},
         '{100, -3, 0, 1'b1, 48'hFFFF_FFFF_FED4, 1},
         '{2, 2, 0, 1'b0, 48'd0, 0},
         '{3, 3, 3, 1'b1, 48'd13, 2},
         '{-131072, -131072, 0, 1'b0, 48'd0, 0},
         '{-131072, -131072, 0, 1'b1, 48'h0008_0000_0000, 2},
         '{-5, 3, 0, 1'b0, 48'd0, 0},
         '{7, -2, 1, 1'b0, 48'd0, 0},
         '{0, 9, 2, 1'b0, 48'd0, 0},
         '{1, 1, 0, 1'b1, 48'hFFFF_FFFF_FFE4, 4}
      };
      for (int k = 0; k < 2; k++) begin
         s_valid[k] = 1'b0; s_a[k] = '0; s_b[k] = '0; s_last[k] = 1'b0;
         res_ready[k] = 1'b1;
      end

      // Reset held 3 cycles
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst s_ready", s_ready[0], 0);
      check("rst dsp_a", dsp_a[0], 0);
      check("rst dsp_b", dsp_b[0], 0);
      check("rst dsp_c", dsp_c[0], 0);
      check("rst dsp_d", dsp_d[0], 0);
      check("rst opmode", dsp_opmode[0], 8'h00);
      check("rst dsp_ce", dsp_ce[0], 0);
      check("rst dsp_rst", dsp_rst[0], 1);
      check("rst res_valid", res_valid[0], 0);
      check("rst res_data", res_data[0], 0);
      check("rst res_terms", res_terms[0], 0);
      check("rst res_trunc", res_trunc[0], 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      check("edge1 dsp_rst", dsp_rst[0], 1);
      check("edge1 dsp_ce", dsp_ce[0], 0);
      check("edge1 s_ready", s_ready[0], 0);
      @(posedge clk); @(negedge clk);
      check("edge2 dsp_rst", dsp_rst[0], 0);
      check("edge2 dsp_ce", dsp_ce[0], 1);
      check("edge2 s_ready", s_ready[0], 1);
      @(posedge clk); #1;

      // Table-driven vectors on instance 0
      for (int i = 0; i < 12; i++) begin
         idle(tbl[i].gap);
         send_beat(0, tbl[i].a[17:0], tbl[i].b[17:0], tbl[i].last, acc_log[i]);
         if (tbl[i].last)
            wait_result(0, tbl[i].exp_data, tbl[i].exp_terms, 1'b0, acc_log[i],
                        $sformatf("vec%0d", i));
      end

      // Opmode tagging relative to dsp_a
      check("v0 first opmode", opm_log[(acc_log[0] + 1) % 1024], 8'h01);
      check("v0 acc opmode", opm_log[(acc_log[1] + 1) % 1024], 8'h09);
      check("single dsp_a", a_log[acc_log[3] % 1024], 18'd100);
      check("single opmode same edge", opm_log[acc_log[3] % 1024], 8'h08);
      check("single opmode next edge", opm_log[(acc_log[3] + 1) % 1024], 8'h01);
      check("single dsp_a next edge", a_log[(acc_log[3] + 1) % 1024], 0);
      check("gap first opmode", opm_log[(acc_log[4] + 1) % 1024], 8'h01);
      for (int g = 2; g <= 4; g++)
         check($sformatf("gap hold opmode %0d", g), opm_log[(acc_log[4] + g) % 1024], 8'h08);
      check("gap acc opmode", opm_log[(acc_log[5] + 1) % 1024], 8'h09);
      check("dsp_c zero", dsp_c[0], 0);
      check("dsp_d zero", dsp_d[0], 0);

      // Result backpressure with a pending beat
      res_ready[0] = 1'b0;
      send_beat(0, 1, 2, 1'b0, e);
      send_beat(0, 3, 4, 1'b1, e);
      s_valid[0] = 1'b1; s_a[0] = 1; s_b[0] = 1; s_last[0] = 1'b1;
      cnt_v = -1;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (res_valid[0]) begin cnt_v = t; break; end
      end
      if (cnt_v < 0) timeout("bp res_valid");
      check("bp terms", res_terms[0], 2);
      for (int t = 0; t < 5; t++) begin
         check("bp res_valid", res_valid[0], 1);
         check("bp res_data", res_data[0], 48'd14);
         check("bp s_ready", s_ready[0], 0);
         check("bp dsp_a", dsp_a[0], 0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      res_ready[0] = 1'b1;
      send_beat(0, 1, 1, 1'b1, e);
      wait_result(0, 48'd1, 1, 1'b0, e, "after bp");

      // MAX_TERMS=4 forced termination on instance 1
      fork
         begin
            for (int k = 0; k < 6; k++) send_beat(1, 1, 1, 1'b0, e1);
         end
         wait_result(1, 48'd4, 4, 1'b1, -1, "trunc");
      join

      // Reset in the middle of the leftover vector
      rst = 1'b1;
      @(negedge clk);
      check("midrst dsp_rst", dsp_rst[1], 1);
      check("midrst s_ready", s_ready[1], 0);
      check("midrst opmode", dsp_opmode[1], 8'h00);
      check("midrst res_trunc", res_trunc[1], 0);
      check("midrst res_terms", res_terms[1], 0);
      idle(2);
      rst = 1'b0;
      cnt_v = 0;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         if (res_valid[0] || res_valid[1]) cnt_v++;
      end
      check("midrst no result", cnt_v, 0);
      @(posedge clk); #1;
      send_beat(1, 2, 5, 1'b1, e);
      wait_result(1, 48'd10, 1, 1'b0, e, "post rst u1");
      send_beat(0, 7, -1, 1'b1, e);
      wait_result(0, 48'hFFFF_FFFF_FFF9, 1, 1'b0, e, "post rst u0");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dsp_dot_seq.md
Name: dsp_dot_seq

Overview:
Upstream operand sequencer for the DSP48A1 slice. It accepts a valid/ready stream of signed 18-bit operand pairs and drives the slice's A/B/C/D/OPMODE/CE/RST ports so the slice computes a dot product, sum(a_i*b_i), over one vector. The vector is delimited by s_last. After the slice pipeline drains, the block captures the 48-bit accumulated P and presents it on a valid/ready result port.

Parameters:
DSP_LAT, 3, edges from dsp_a/dsp_b update to P valid: A1 reg + M reg + P reg.
OPMODE_DLY, 1, edges dsp_opmode lags dsp_a/dsp_b (equals MREG).
MAX_TERMS, 1024, maximum terms per vector before forced termination.
CNT_W, 11, width of term counter; must satisfy 2^CNT_W > MAX_TERMS.

Ports:
CLK  in  1  clock
RST  in  1  asynchronous, active-high reset
s_valid  in  1  operand pair valid
s_ready  out  1  block can accept a pair
s_a  in  18  signed operand a
s_b  in  18  signed operand b
s_last  in  1  final pair of the vector
dsp_a  out  18  to slice A
dsp_b  out  18  to slice B (B_INPUT="DIRECT")
dsp_c  out  48  to slice C; constant 0
dsp_d  out  18  to slice D; constant 0
dsp_opmode  out  8  to slice OPMODE
dsp_ce  out  1  drives all slice CE* inputs; constant 1 after reset
dsp_rst  out  1  drives all slice RST* inputs (slice reset is SYNC)
dsp_p  in  48  slice P
res_valid  out  1  result valid
res_ready  in  1  result accepted
res_data  out  48  signed dot product
res_terms  out  CNT_W  number of terms accumulated
res_trunc  out  1  vector force-ended at MAX_TERMS

Behaviour:
- Reset values: s_ready=0, dsp_a/b/c/d=0, dsp_opmode=8'h00, dsp_ce=0, dsp_rst=1, res_valid=0, res_data=0, res_terms=0, res_trunc=0, state=IDLE.
- dsp_rst is set asynchronously by RST and clears on the 2nd rising edge after RST deasserts. This guarantees the synchronous slice reset sees at least one clock edge.
- dsp_ce rises together with dsp_rst falling. s_ready is 0 while dsp_rst=1.
- All dsp_* outputs are registered. The slice runs with A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, CARRYINSEL="OPMODE5".
- OPMODE codes:
  - FIRST = 8'h01 (X=M, Z=0).
  - ACC = 8'h09 (X=M, Z=P).
  - HOLD = 8'h08 (X=0, Z=P).
  - Pre-adder, pre-sub, post-sub and carry bits are always 0.
- A beat is accepted on a rising edge with s_valid && s_ready. On that edge dsp_a/dsp_b load s_a/s_b.
- The beat's opmode tag (FIRST if it is the first beat of the vector, else ACC) goes into an OPMODE_DLY-deep delay line. The line's output is dsp_opmode.
- If no beat is accepted, dsp_a/dsp_b load 0 and the tag HOLD enters the delay line.
- States:
  - IDLE: s_ready=1. On accept → ACCUM, or → DRAIN if s_last. Term counter is set to 1.
  - ACCUM: s_ready=1. Each accept increments the counter. On s_last, or when the counter reaches MAX_TERMS → DRAIN; res_trunc is set if MAX_TERMS is reached without s_last. Gaps (s_valid=0) insert HOLD.
  - DRAIN: s_ready=0. Drain counter is loaded with DSP_LAT+OPMODE_DLY-1 on entry and decrements. At 0, res_data<=dsp_p and res_terms<=counter → OUT.
  - OUT: res_valid=1, s_ready=0. On res_ready → IDLE; res_valid drops on the same edge. res_data/res_terms/res_trunc hold until the next capture.
- Latency: last beat accepted at edge E → P valid at E+DSP_LAT → res_valid rises at E+DSP_LAT+1.
- Arithmetic: signed 18x18 → 36-bit, sign-extended to 48 by the slice. Wrap-around is 48-bit two's complement; no saturation.
- res_valid is held while res_ready=0, with no new input accepted.
- Reset mid-vector: all state is discarded immediately and the output returns to reset values. No partial result is emitted.

Decomposition:
- Package dsp_seq_pkg holds the OPMODE_FIRST/ACC/HOLD constants, the state enum (IDLE, ACCUM, DRAIN, OUT) and the slice configuration constants listed above.
- One sub-module, dsp_seq_dly: a parameterised depth-N register delay line with reset, used for the opmode tag.

Test Plan:
- Reset held 3 cycles, then released → dsp_rst falls on the 2nd edge; during reset all outputs are at reset values; s_ready rises with dsp_ce.
- Vector (3,4),(5,6),(-2,7)+last, back-to-back, res_ready=1 → res_data=48'd28, res_terms=3, res_valid at last-accept+4 edges.
- Single term (100,-3)+last → res_data=48'hFFFFFFFFFED4, res_terms=1; dsp_opmode shows 8'h01 exactly one edge after dsp_a=100.
- Vector (2,2),gap×3,(3,3)+last → res_data=13; dsp_opmode=8'h08 during gap slots.
- res_ready=0 for 5 cycles, s_valid=1 throughout → res_valid and data stable, s_ready=0, no beats lost. After res_ready, the next vector (1,1)+last → 1 (no stale P).
- MAX_TERMS=4 override, 6 beats of (1,1), no s_last → res_data=4, res_trunc=1. RST asserted mid-vector → no res_valid, next vector correct.
